// File: rtl/fb_scan.sv
// fb_scan: raster frame-buffer scanner feeding a valid/ready pixel stream via a 2-entry FIFO.
// Build option FB_SCAN_GRAY_EN replaces the output pixel with its gray value {y,y,y}.
module fb_scan #(
    parameter int H_PIX   = 256,  // power of two, 2..1024
    parameter int V_LINES = 256   // 1..1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [19:0] fb_base,
    output logic        fb_ren,
    output logic [19:0] fb_a,
    input  logic [23:0] fb_q,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy,
    output logic        done
);

    localparam int            CW       = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(H_PIX - 1);
    localparam logic [9:0]    ROW_LAST = 10'(V_LINES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        logic        eof;
    } ent_t;

    state_t        state, state_nx;
    logic [19:0]   base_q;
    logic [CW-1:0] col;
    logic [9:0]    row;
    logic          last_col, last_pix;

    logic          rd_pend;
    logic [2:0]    pend_tag;
    ent_t          pend_ent;

    ent_t          fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    ent_t          head;
    logic          pop, push, fifo_pop;
    logic [2:0]    occ;

    assign last_col = (col == COL_LAST);
    assign last_pix = last_col && (row == ROW_LAST);
    assign fb_a     = base_q + (20'(row) << CW) + 20'(col);

    // The returning read word acts as the FIFO's entry stage: it is visible on
    // the output the same cycle fb_q is valid, and is only written into the
    // storage if the sink does not take it right away.
    assign pend_ent  = '{rgb: fb_q, sof: pend_tag[2], eol: pend_tag[1], eof: pend_tag[0]};
    assign pix_valid = (count != 2'd0) || rd_pend;
    assign head      = (count != 2'd0) ? fifo_mem[rd_ptr] : (rd_pend ? pend_ent : '0);

    assign pop      = pix_valid && pix_ready;
    assign fifo_pop = pop && (count != 2'd0);
    assign push     = rd_pend && !(pop && count == 2'd0);
    assign occ      = {1'b0, count} + {2'b00, rd_pend} - {2'b00, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fb_ren   = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                fb_ren = (occ < 3'd2);
                if (fb_ren && last_pix) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && head.eof) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            col    <= '0;
            row    <= '0;
        end else if (state == IDLE && start) begin
            base_q <= fb_base;
            col    <= '0;
            row    <= '0;
        end else if (fb_ren) begin
            if (last_col) begin
                col <= '0;
                row <= row + 10'd1;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Flags are tagged at issue time and ride alongside the read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend  <= 1'b0;
            pend_tag <= '0;
        end else begin
            rd_pend  <= fb_ren;
            pend_tag <= {(col == '0) && (row == '0), last_col, last_pix};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= pend_ent;
                wr_ptr           <= ~wr_ptr;
            end
            if (fifo_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, fifo_pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) done <= 1'b0;
        else        done <= (state == DRAIN) && pop && head.eof;
    end

    assign pix_sof = head.sof;
    assign pix_eol = head.eol;
    assign pix_eof = head.eof;

`ifdef FB_SCAN_GRAY_EN
    logic [9:0] luma;
    assign luma     = 10'(head.rgb[23:16]) + {1'b0, head.rgb[15:8], 1'b0} + 10'(head.rgb[7:0]);
    assign pix_data = {3{luma[9:2]}};
`else
    assign pix_data = head.rgb;
`endif

endmodule

// File: tb/tb_fb_scan.sv
// tb_fb_scan: table-driven frame scans with a pixel/address scoreboard, plus stall and reset sequences.
module tb_fb_scan;
    localparam int H = 4, V = 2, NPIX = H * V;

    logic        clk = 1'b0;
    logic        reset, start, pix_ready;
    logic [19:0] fb_base;
    logic        fb_ren, pix_valid, pix_sof, pix_eol, pix_eof, busy, done;
    logic [19:0] fb_a;
    logic [23:0] fb_q = '0;
    logic [23:0] pix_data;
    logic [3:0]  mem_hi;

    fb_scan #(.H_PIX(H), .V_LINES(V)) dut (
        .clk(clk), .reset(reset), .start(start), .fb_base(fb_base),
        .fb_ren(fb_ren), .fb_a(fb_a), .fb_q(fb_q),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // memory: word = {mem_hi, address}, one-cycle read latency
    always @(posedge clk) if (fb_ren) fb_q <= {mem_hi, fb_a};

    typedef struct { logic [23:0] data; logic sof, eol, eof; } pix_t;
    typedef struct { logic [19:0] base; logic [3:0] hi; int mode; int exp_done; } vec_t;

    pix_t        sb[$];
    logic [19:0] addr_q[$];
    int          n_chk, n_fail;
    logic [23:0] first_data;
    vec_t        vec[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [23:0] exp_pix(input logic [23:0] w);
`ifdef FB_SCAN_GRAY_EN
        logic [9:0] s;
        s = 10'(w[23:16]) + {1'b0, w[15:8], 1'b0} + 10'(w[7:0]);
        return {3{s[9:2]}};
`else
        return w;
`endif
    endfunction

    function automatic logic ready_at(input int mode, input int k);
        case (mode)
            0: return 1'b1;
            1: return (k % 2 == 0);
            2: return 1'($urandom_range(0, 1));
            3: return (k > 10);
            default: return 1'b1;
        endcase
    endfunction

    // Entered just after a negedge with the DUT idle; that cycle carries start, edge 0 follows.
    task automatic run_frame(input int mode, input logic [19:0] base, input int exp_done);
        pix_t        e;
        int          issued, popped, done_k, first_vld, ren_viol, stall_viol;
        logic        stall_prev, vld_window_ok;
        logic [26:0] prev;
        for (int i = 0; i < NPIX; i++) begin
            e.data = exp_pix({mem_hi, base + 20'(i)});
            e.sof  = (i == 0);
            e.eol  = (i % H == H - 1);
            e.eof  = (i == NPIX - 1);
            sb.push_back(e);
            addr_q.push_back(base + 20'(i));
        end
        fb_base = base; start = 1'b1; pix_ready = ready_at(mode, 0);
        issued = 0; popped = 0; done_k = 0; first_vld = 0; ren_viol = 0; stall_viol = 0;
        stall_prev = 1'b0; vld_window_ok = 1'b1; prev = '0;
        for (int k = 1; k <= 200 && done_k == 0; k++) begin
            @(negedge clk);
            start     = (mode == 3 && k == 5);
            pix_ready = ready_at(mode, k);
            #1;
            if (pix_valid && first_vld == 0) first_vld = k;
            if (stall_prev && {pix_valid, pix_data, pix_sof, pix_eol, pix_eof} !== {1'b1, prev}) stall_viol++;
            stall_prev = pix_valid && !pix_ready;
            prev       = {pix_data, pix_sof, pix_eol, pix_eof};
            if (mode == 3 && k >= 2 && k <= 10 && !pix_valid) vld_window_ok = 1'b0;
            if (fb_ren) begin
                if (issued - popped - int'(pix_valid && pix_ready) >= 2) ren_viol++;
                issued++;
                if (addr_q.size() == 0) fail_now("unexpected_read");
                else chk("fb_a", 64'(fb_a), 64'(addr_q.pop_front()));
            end
            if (mode == 3 && k == 10) chk("stalled_read_count", 64'(issued), 64'(2));
            if (pix_valid && pix_ready) begin
                if (popped == 0) first_data = pix_data;
                popped++;
                if (sb.size() == 0) fail_now("unexpected_pixel");
                else begin
                    e = sb.pop_front();
                    chk("pixel", 64'({pix_data, pix_sof, pix_eol, pix_eof}), 64'({e.data, e.sof, e.eol, e.eof}));
                end
            end
            if (done) begin
                done_k = k;
                chk("busy_done_at_done", 64'({busy, done}), 64'(2'b01));
            end
        end
        if (done_k == 0) fail_now("frame_timeout");
        else begin
            @(negedge clk); #1;
            chk("done_one_cycle", 64'(done), 64'(0));
        end
        chk("first_valid_cycle", 64'(first_vld), 64'(2));
        if (exp_done != 0) chk("done_cycle", 64'(done_k), 64'(exp_done));
        chk("read_count", 64'(issued), 64'(NPIX));
        chk("overfill_reads", 64'(ren_viol), 64'(0));
        chk("stall_stability", 64'(stall_viol), 64'(0));
        chk("scoreboard_empty", 64'(sb.size() + addr_q.size()), 64'(0));
        if (mode == 3) chk("valid_held_in_stall", 64'(vld_window_ok), 64'(1));
        sb.delete();
        addr_q.delete();
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b0; start = 1'b0; pix_ready = 1'b0; fb_base = '0; mem_hi = '0;
        vec[0] = '{20'h00100, 4'h0, 0, 10};  // basic, ready=1
        vec[1] = '{20'h00100, 4'h0, 1, 17};  // ready toggling
        vec[2] = '{20'hFFFFE, 4'h0, 0, 10};  // address wrap
        vec[3] = '{20'h02030, 4'h1, 0, 10};  // first word 0x102030
        vec[4] = '{20'h55555, 4'h0, 2, 0};   // random backpressure
        vec[5] = '{20'h00100, 4'h0, 3, 19};  // ready low 10 cycles, start pulsed in RUN

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 64'({busy, done, fb_ren, fb_a, pix_valid, pix_data, pix_sof, pix_eol, pix_eof}), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            mem_hi = vec[v].hi;
            run_frame(vec[v].mode, vec[v].base, vec[v].exp_done);
`ifdef FB_SCAN_GRAY_EN
            if (v == 3) chk("gray_first_pixel", 64'(first_data), 64'(24'h202020));
`else
            if (v == 3) chk("rgb_first_pixel", 64'(first_data), 64'(24'h102030));
`endif
            @(negedge clk);
        end

        // reset at pixel 3 of a frame
        mem_hi = '0; fb_base = 20'h00100; start = 1'b1; pix_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("pixel3_before_reset", 64'(pix_data), 64'(exp_pix(24'h000103)));
        reset = 1'b0;
        #1;
        chk("midframe_reset_outputs", 64'({busy, done, fb_ren, fb_a, pix_valid, pix_data, pix_sof, pix_eol, pix_eof}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("idle_after_reset", 64'({pix_valid, busy, fb_ren}), 64'(0));
        end
        run_frame(0, 20'h00200, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_scan.md
FB_SCAN -- requirements
Module: fb_scan

Interface
REQ-001 Parameter H_PIX, default 256, pixels per line; must be a power of two in the range 2..1024.
REQ-002 Parameter V_LINES, default 256, lines per frame; must be in the range 1..1024.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to begin a frame scan.
REQ-006 fb_base  input  20  frame-buffer base word address.
REQ-007 fb_ren  output  1  frame-buffer read strobe.
REQ-008 fb_a  output  20  frame-buffer read address.
REQ-009 fb_q  input  24  read data {R,G,B}, valid exactly one cycle after fb_ren.
REQ-010 pix_data  output  24  pixel {R,G,B}.
REQ-011 pix_valid  output  1  pix_data is valid.
REQ-012 pix_ready  input  1  the sink accepts the pixel.
REQ-013 pix_sof, pix_eol, pix_eof  output  1 each  first-of-frame, last-of-line and last-of-frame flags, qualified by pix_valid.
REQ-014 busy  output  1  a scan is in progress.
REQ-015 done  output  1  one-cycle frame-complete pulse.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-017 In IDLE, a sampled start SHALL latch fb_base, clear the column and row counters, and move the FSM to RUN; busy SHALL be 1 in RUN and DRAIN.
REQ-018 start SHALL be ignored in RUN and in DRAIN.
REQ-019 fb_a SHALL equal fb_base + row*H_PIX + col, computed modulo 2^20, so the address wraps past 0xFFFFF.
REQ-020 A 2-entry output FIFO SHALL capture fb_q on the cycle after each fb_ren.
REQ-021 fb_ren SHALL assert only when (FIFO count + in-flight reads - pop this cycle) < 2; the FIFO never overflows.
REQ-022 Each fb_ren SHALL advance col; at col == H_PIX-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 Issuing the read for pixel H_PIX*V_LINES-1 SHALL move the FSM to DRAIN, and no further fb_ren SHALL assert.
REQ-024 pix_valid SHALL equal FIFO non-empty; a pop SHALL occur only on pix_valid && pix_ready.
REQ-025 pix_data and the flags SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-026 The flags SHALL travel with their pixel through the FIFO: sof on pixel 0, eol on col H_PIX-1, eof on the final pixel.
REQ-027 DRAIN SHALL return to IDLE on the cycle after the eof handshake; done SHALL be 1 for exactly that one cycle.
REQ-028 Timing: start sampled at edge 0 -> fb_ren high in cycle 1 -> pix_valid high from cycle 2.
REQ-029 With pix_ready held at 1, the block SHALL deliver one pixel per cycle with no bubbles.
REQ-030 Simultaneous push and pop SHALL leave the FIFO count unchanged.

Reset
REQ-031 While reset=0, the following SHALL be held at 0 asynchronously: busy, done, fb_ren, fb_a, pix_valid, pix_data, all flags, FIFO count and in-flight state; the FSM SHALL be in IDLE.
REQ-032 Reset asserted mid-frame SHALL discard FIFO contents and in-flight data; fb_q arriving after reset release SHALL be ignored.
REQ-033 The first start after reset release SHALL restart the scan at pixel 0 with sof.

Configuration
REQ-034 With macro FB_SCAN_GRAY_EN defined, pix_data SHALL equal {y,y,y}, where y = (R + 2*G + B) >> 2 computed in 10 bits from the FIFO head; latency and flags are unchanged.
REQ-035 With FB_SCAN_GRAY_EN undefined, pix_data SHALL equal the FIFO head unmodified and no gray logic shall be present.

Verification
REQ-036 H_PIX=4, V_LINES=2, fb_base=0x00100, memory word = address, ready=1 -> pixels 0x000100..0x000107 on cycles 2..9; sof on 0x100; eol on 0x103 and 0x107; eof on 0x107; done in cycle 10.
REQ-037 Same setup with pix_ready toggling 1,0,1,0 -> identical pixel sequence; data is stable during stalls; fb_ren never asserts when occupancy is 2.
REQ-038 fb_base=0xFFFFE, H_PIX=4, V_LINES=1 -> fb_a sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
REQ-039 pix_ready held at 0 for 10 cycles after start -> exactly 2 fb_ren pulses and pix_valid held high; start pulsed in RUN has no effect.
REQ-040 reset driven low at pixel 3 -> all outputs read 0 immediately; start after release -> sof pixel read from fb_base.
REQ-041 FB_SCAN_GRAY_EN defined, fb_q=0x102030 -> pix_data=0x202020.
